lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit: the memory-access stage directly downstream of the ALU/execute stage.
- Accepts one load or store request per transaction, using the ALU-computed effective address and the rs2 store value.
- Drives the word-addressed data-memory port with byte enables, waits for a completion ack, then returns sign- or zero-extended load data and an error code to write-back.
- The core stalls on busy while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: ACCESS cycles without mem_ack before a bus-timeout error; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width field: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_address  out  32  word-aligned address {addr[31:2],2'b00}
- mem_read_enable  out  1  load in progress
- mem_write_enable  out  1  store in progress
- mem_byte_enable  out  4  active byte lanes
- mem_write_data  out  32  lane-positioned store data
- mem_read_data  in  32  word read data, valid when mem_ack=1
- mem_ack  in  1  memory completes the current access
- busy  out  1  state != IDLE
- wb_valid  out  1  one-cycle completion pulse
- wb_reg_write  out  1  write-back required: load, err=0, rd!=0
- wb_rd  out  5  latched rd
- wb_data  out  32  extended load data; 0 for stores and errors
- err  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal funct3

Behaviour:
- Reset (async) forces IDLE. All outputs 0 except req_ready=1. Memory enables drop immediately, even mid-ACCESS. The in-flight transaction is discarded and produces no wb_valid.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Request accepted on the clock edge where req_valid & req_ready. Latch is_store, funct3, addr, wdata, rd.
  - Illegal funct3 (loads: 3,6,7; stores: >=3) goes to RESP with err=3.
  - Misaligned address (H: addr[0]!=0; W: addr[1:0]!=0) goes to RESP with err=1.
  - Neither error case drives any memory enable. Otherwise go to ACCESS.
- ACCESS:
  - mem_address, enables, byte_enable and write_data are held stable, registered from the latched request.
  - Timeout counter is cleared on entry and increments each cycle without ack.
  - On mem_ack: latch extracted data for loads, go to RESP with err=0.
  - When the counter reaches TIMEOUT_CYCLES without ack: go to RESP with err=2, enables drop.
  - mem_ack in IDLE or RESP is ignored.
- RESP: wb_valid=1 for exactly one cycle with wb_rd, wb_data, err, wb_reg_write, then go to IDLE. No back-pressure.
- Store lanes:
  - SB: byte replicated to all four lanes; be = 1<<addr[1:0].
  - SH: halfword replicated to both halves; be = 4'b0011 (addr[1]=0) or 4'b1100.
  - SW: be = 4'b1111.
- Load lanes:
  - Extract byte at addr[1:0] or halfword at addr[1], shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Read-side byte_enable uses the same pattern as stores.
- Latency: acceptance at edge N; ACCESS in cycle N+1; with mem_ack in cycle N+1, wb_valid in cycle N+2. Error paths: wb_valid in cycle N+1.
- Throughput: at most one transaction per 3 cycles. req_ready is low in ACCESS and RESP, so requests presented then are not accepted.

Test Plan:
- LW addr 0x100, mem_read_data 0xDEADBEEF, ack in the first ACCESS cycle, rd=5: mem_address 0x100, be 1111; wb_valid exactly 2 cycles after acceptance; wb_data 0xDEADBEEF, wb_reg_write=1, err=0.
- LB addr 0x103 and LBU addr 0x103, read data 0x80FF7F01: LB gives wb_data 0xFFFFFF80; LBU gives 0x00000080; be 1000 in both cases.
- SH addr 0x22, wdata 0x1234ABCD, ack after 3 wait cycles: mem_address 0x20, be 1100, write_data 0xABCDABCD held stable all 4 ACCESS cycles; wb_valid with wb_reg_write=0.
- LW addr 0x102 and LH addr 0x101: err=1 one cycle after acceptance; mem_read_enable never asserted; wb_reg_write=0.
- TIMEOUT_CYCLES=4, SW with no ack: err=2 after 4 ACCESS cycles. Repeat with reset asserted in the 2nd ACCESS cycle: enables drop asynchronously, no wb_valid, req_ready=1.
- Load funct3=3: err=3. LW with rd=0: wb_valid=1, wb_reg_write=0.

Source files
------------

// File: rtl/lsu_if.sv
// Request, data-memory and write-back signal bundle of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ack;
  logic        busy;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_read_data, mem_ack,
    output req_ready, mem_address, mem_read_enable, mem_write_enable,
    output mem_byte_enable, mem_write_data, busy,
    output wb_valid, wb_reg_write, wb_rd, wb_data, err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_read_data, mem_ack,
    input  req_ready, mem_address, mem_read_enable, mem_write_enable,
    input  mem_byte_enable, mem_write_data, busy,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, err
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP, with
// lane steering for stores, sign/zero extension for loads and a bus timeout.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic  clock,
  input  logic  reset,
  lsu_if.slave  bus
);

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_ACCESS    = 2'd1;
  localparam logic [1:0]  ST_RESP      = 2'd2;
  localparam logic [1:0]  ERR_NONE     = 2'd0;
  localparam logic [1:0]  ERR_MISALIGN = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0]  ERR_FUNCT3   = 2'd3;
  localparam logic [31:0] TMO_LIMIT    = 32'(TIMEOUT_CYCLES);

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    case (is_store)
      1'b1:    bad = f3[2] || (f3[1:0] == 2'b11);
      default: bad = (f3[1:0] == 2'b11) || (f3 == 3'd6);
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return rdata;
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic        req_ready_r, busy_r, is_store_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [4:0]  rd_r;
  logic [31:0] tmo_cnt_r;
  logic [31:0] mem_address_r, mem_wdata_r, wb_data_r;
  logic        mem_re_r, mem_we_r, wb_valid_r, wb_reg_write_r;
  logic [3:0]  mem_be_r;
  logic [1:0]  err_r;

  logic        illegal_s, misalign_s, tmo_hit_s, done_s;
  logic [3:0]  req_be_s;
  logic [31:0] req_wdata_s, load_data_s;

  // Decode of the presented request, the returned read word and the timeout.
  always_comb begin
    illegal_s   = f3_illegal(bus.req_is_store, bus.req_funct3);
    misalign_s  = f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    req_be_s    = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
    req_wdata_s = store_lanes(bus.req_funct3, bus.req_wdata);
    load_data_s = load_extend(funct3_r, addr_lo_r, bus.mem_read_data);
    tmo_hit_s   = (TIMEOUT_CYCLES != 0) && ((tmo_cnt_r + 32'd1) == TMO_LIMIT);
    done_s      = bus.mem_ack || tmo_hit_s;
  end

  // Transaction FSM; memory-port and write-back outputs are all registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      req_ready_r    <= 1'b1;
      busy_r         <= 1'b0;
      is_store_r     <= 1'b0;
      funct3_r       <= 3'd0;
      addr_lo_r      <= 2'd0;
      rd_r           <= 5'd0;
      tmo_cnt_r      <= 32'd0;
      mem_address_r  <= 32'd0;
      mem_wdata_r    <= 32'd0;
      mem_re_r       <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_be_r       <= 4'd0;
      wb_valid_r     <= 1'b0;
      wb_reg_write_r <= 1'b0;
      wb_data_r      <= 32'd0;
      err_r          <= ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            is_store_r  <= bus.req_is_store;
            funct3_r    <= bus.req_funct3;
            addr_lo_r   <= bus.req_addr[1:0];
            rd_r        <= bus.req_rd;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            // Decode errors skip the memory entirely and report straight away.
            if (illegal_s) begin
              state_r    <= ST_RESP;
              wb_valid_r <= 1'b1;
              err_r      <= ERR_FUNCT3;
            end else if (misalign_s) begin
              state_r    <= ST_RESP;
              wb_valid_r <= 1'b1;
              err_r      <= ERR_MISALIGN;
            end else begin
              state_r       <= ST_ACCESS;
              tmo_cnt_r     <= 32'd0;
              mem_address_r <= {bus.req_addr[31:2], 2'b00};
              mem_re_r      <= ~bus.req_is_store;
              mem_we_r      <= bus.req_is_store;
              mem_be_r      <= req_be_s;
              mem_wdata_r   <= bus.req_is_store ? req_wdata_s : 32'd0;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (done_s) begin
            state_r        <= ST_RESP;
            mem_address_r  <= 32'd0;
            mem_wdata_r    <= 32'd0;
            mem_re_r       <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_be_r       <= 4'd0;
            wb_valid_r     <= 1'b1;
            err_r          <= bus.mem_ack ? ERR_NONE : ERR_TIMEOUT;
            wb_data_r      <= (bus.mem_ack && !is_store_r) ? load_data_s : 32'd0;
            wb_reg_write_r <= bus.mem_ack && !is_store_r && (rd_r != 5'd0);
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        ST_RESP: begin
          state_r        <= ST_IDLE;
          req_ready_r    <= 1'b1;
          busy_r         <= 1'b0;
          wb_valid_r     <= 1'b0;
          wb_reg_write_r <= 1'b0;
          wb_data_r      <= 32'd0;
          err_r          <= ERR_NONE;
        end
        default: begin
          state_r        <= ST_IDLE;
          req_ready_r    <= 1'b1;
          busy_r         <= 1'b0;
          mem_re_r       <= 1'b0;
          mem_we_r       <= 1'b0;
          mem_be_r       <= 4'd0;
          wb_valid_r     <= 1'b0;
          wb_reg_write_r <= 1'b0;
          err_r          <= ERR_NONE;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_r;
  assign bus.busy             = busy_r;
  assign bus.mem_address      = mem_address_r;
  assign bus.mem_read_enable  = mem_re_r;
  assign bus.mem_write_enable = mem_we_r;
  assign bus.mem_byte_enable  = mem_be_r;
  assign bus.mem_write_data   = mem_wdata_r;
  assign bus.wb_valid         = wb_valid_r;
  assign bus.wb_reg_write     = wb_reg_write_r;
  assign bus.wb_rd            = rd_r;
  assign bus.wb_data          = wb_data_r;
  assign bus.err              = err_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected write-backs are queued at request time
// and compared when wb_valid pulses.
module tb_lsu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lsu_if bus();
  lsu #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  err;
    logic        rw;
  } wb_t;

  wb_t sb_q[$];
  wb_t wb_now;
  assign wb_now = {bus.wb_rd, bus.wb_data, bus.err, bus.wb_reg_write};

  int tests_run = 0;
  int fails     = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single edge; optionally queue its expected write-back.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] xdata, input logic [1:0] xerr, input bit push);
    wb_t x;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    x.rd   = rd;
    x.data = xdata;
    x.err  = xerr;
    x.rw   = !st && (xerr == 2'd0) && (rd != 5'd0);
    if (push) sb_q.push_back(x);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int bound, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc <= bound) begin
      if (bus.wb_valid === 1'b1) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] got;
    got = {bus.req_ready, bus.busy, bus.wb_valid, bus.wb_reg_write, bus.mem_read_enable,
           bus.mem_write_enable, bus.mem_byte_enable, bus.err, bus.wb_rd};
    tests_run++;
    if (got !== 17'h10000 || {bus.mem_address, bus.mem_write_data, bus.wb_data} !== 96'd0) begin
      fails++;
      $display("FAIL reset_state: got ctl=%h, want 10000", got);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if ({bus.req_ready, bus.busy, bus.wb_valid} !== 3'b100) begin
      fails++;
      $display("FAIL reset_idle: got %b, want 100", {bus.req_ready, bus.busy, bus.wb_valid});
    end
  endtask

  task automatic test_lw();
    int cyc;
    bit seen;
    wb_t e;
    issue(1'b0, 3'd2, 32'h100, 32'd0, 5'd5, 32'hDEADBEEF, 2'd0, 1'b1);
    tests_run++;
    if ({bus.mem_address, bus.mem_byte_enable, bus.mem_read_enable, bus.mem_write_enable,
         bus.busy, bus.req_ready} !== {32'h100, 4'b1111, 4'b1010}) begin
      fails++;
      $display("FAIL lw_access: addr=%h be=%b re=%b we=%b, want 100 1111 1 0",
               bus.mem_address, bus.mem_byte_enable, bus.mem_read_enable, bus.mem_write_enable);
    end
    bus.mem_read_data = 32'hDEADBEEF;
    bus.mem_ack = 1'b1;
    wait_wb(8, cyc, seen);
    bus.mem_ack = 1'b0;
    tests_run++;
    if (!seen || cyc != 1) begin
      fails++;
      $display("FAIL lw_latency: seen=%0d cyc=%0d, want seen=1 cyc=1", seen, cyc);
    end
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    tests_run++;
    if (wb_now !== e) begin
      fails++;
      $display("FAIL lw_wb: got %h, want %h", wb_now, e);
    end
    step();
    tests_run++;
    if ({bus.wb_valid, bus.req_ready, bus.busy} !== 3'b010) begin
      fails++;
      $display("FAIL lw_pulse: got %b, want 010", {bus.wb_valid, bus.req_ready, bus.busy});
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3_t [0:4];
    logic [31:0] a_t  [0:4];
    logic [31:0] x_t  [0:4];
    logic [3:0]  be_t [0:4];
    int cyc;
    bit seen;
    wb_t e;
    f3_t = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
    a_t  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    x_t  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
    be_t = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3_t[i], a_t[i], 32'd0, 5'(7 + i), x_t[i], 2'd0, 1'b1);
      tests_run++;
      if ({bus.mem_address, bus.mem_byte_enable} !== {32'h100, be_t[i]}) begin
        fails++;
        $display("FAIL load_lanes[%0d]: addr=%h be=%b, want 100 %b", i,
                 bus.mem_address, bus.mem_byte_enable, be_t[i]);
      end
      bus.mem_read_data = 32'h80FF7F01;
      bus.mem_ack = 1'b1;
      wait_wb(8, cyc, seen);
      bus.mem_ack = 1'b0;
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      tests_run++;
      if (!seen || wb_now !== e) begin
        fails++;
        $display("FAIL load_ext[%0d]: seen=%0d got %h, want %h", i, seen, wb_now, e);
      end
      step();
    end
  endtask

  task automatic test_store_wait();
    int cyc;
    bit seen;
    wb_t e;
    issue(1'b1, 3'd1, 32'h22, 32'h1234ABCD, 5'd9, 32'd0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({bus.mem_address, bus.mem_byte_enable, bus.mem_write_data, bus.mem_write_enable,
           bus.mem_read_enable} !== {32'h20, 4'b1100, 32'hABCDABCD, 2'b10}) begin
        fails++;
        $display("FAIL sh_hold[%0d]: addr=%h be=%b wd=%h we=%b, want 20 1100 abcdabcd 1", k,
                 bus.mem_address, bus.mem_byte_enable, bus.mem_write_data, bus.mem_write_enable);
      end
      if (k < 3) step();
      else bus.mem_ack = 1'b1;
    end
    wait_wb(8, cyc, seen);
    bus.mem_ack = 1'b0;
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    tests_run++;
    if (!seen || cyc != 1 || wb_now !== e || bus.mem_write_enable !== 1'b0) begin
      fails++;
      $display("FAIL sh_wb: seen=%0d cyc=%0d we=%b got %h, want cyc=1 we=0 %h",
               seen, cyc, bus.mem_write_enable, wb_now, e);
    end
    step();
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3_t [0:1];
    logic [31:0] a_t  [0:1];
    logic [31:0] wd_t [0:1];
    logic [67:0] x_t  [0:1];
    int cyc;
    bit seen;
    wb_t e;
    f3_t = '{3'd0, 3'd2};
    a_t  = '{32'h21, 32'h24};
    wd_t = '{32'h1234565A, 32'hCAFEBABE};
    x_t  = '{{32'h20, 4'b0010, 32'h5A5A5A5A}, {32'h24, 4'b1111, 32'hCAFEBABE}};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, f3_t[i], a_t[i], wd_t[i], 5'd1, 32'd0, 2'd0, 1'b1);
      tests_run++;
      if ({bus.mem_address, bus.mem_byte_enable, bus.mem_write_data} !== x_t[i]) begin
        fails++;
        $display("FAIL store_lanes[%0d]: got %h, want %h", i,
                 {bus.mem_address, bus.mem_byte_enable, bus.mem_write_data}, x_t[i]);
      end
      bus.mem_ack = 1'b1;
      wait_wb(8, cyc, seen);
      bus.mem_ack = 1'b0;
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      tests_run++;
      if (!seen || wb_now !== e) begin
        fails++;
        $display("FAIL store_wb[%0d]: seen=%0d got %h, want %h", i, seen, wb_now, e);
      end
      step();
    end
  endtask

  task automatic test_decode_errors();
    logic        st_t [0:5];
    logic [2:0]  f3_t [0:5];
    logic [31:0] a_t  [0:5];
    logic [1:0]  x_t  [0:5];
    wb_t e;
    st_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    f3_t = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd6, 3'd3};
    a_t  = '{32'h102, 32'h101, 32'h103, 32'h100, 32'h100, 32'h100};
    x_t  = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      issue(st_t[i], f3_t[i], a_t[i], 32'h55AA55AA, 5'd12, 32'd0, x_t[i], 1'b1);
      tests_run++;
      if ({bus.wb_valid, bus.mem_read_enable, bus.mem_write_enable, bus.mem_byte_enable}
          !== 7'b1000000) begin
        fails++;
        $display("FAIL err_path[%0d]: wb_valid=%b re=%b we=%b be=%b, want 1 0 0 0000", i,
                 bus.wb_valid, bus.mem_read_enable, bus.mem_write_enable, bus.mem_byte_enable);
      end
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      tests_run++;
      if (wb_now !== e) begin
        fails++;
        $display("FAIL err_wb[%0d]: got %h, want %h", i, wb_now, e);
      end
      step();
    end
  endtask

  task automatic test_rd_zero();
    int cyc;
    bit seen;
    wb_t e;
    issue(1'b0, 3'd2, 32'h300, 32'd0, 5'd0, 32'h11223344, 2'd0, 1'b1);
    bus.mem_read_data = 32'h11223344;
    bus.mem_ack = 1'b1;
    wait_wb(8, cyc, seen);
    bus.mem_ack = 1'b0;
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    tests_run++;
    if (!seen || wb_now !== e) begin
      fails++;
      $display("FAIL rd_zero: seen=%0d got %h, want %h", seen, wb_now, e);
    end
    step();
  endtask

  task automatic test_timeout();
    int wb_cnt;
    wb_t e;
    issue(1'b1, 3'd2, 32'h40, 32'h0BADF00D, 5'd3, 32'd0, 2'd2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({bus.busy, bus.mem_write_enable, bus.wb_valid} !== 3'b110) begin
        fails++;
        $display("FAIL tmo_access[%0d]: busy/we/wb=%b, want 110", k,
                 {bus.busy, bus.mem_write_enable, bus.wb_valid});
      end
      step();
    end
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    tests_run++;
    if (bus.wb_valid !== 1'b1 || bus.mem_write_enable !== 1'b0 || wb_now !== e) begin
      fails++;
      $display("FAIL tmo_wb: wb_valid=%b we=%b got %h, want 1 0 %h",
               bus.wb_valid, bus.mem_write_enable, wb_now, e);
    end
    step();
    // Same store again, aborted by reset in its second access cycle.
    issue(1'b1, 3'd2, 32'h40, 32'h0BADF00D, 5'd3, 32'd0, 2'd2, 1'b0);
    step();
    tests_run++;
    if (bus.mem_write_enable !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: we=%b, want 1", bus.mem_write_enable);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.mem_write_enable, bus.mem_read_enable, bus.busy, bus.req_ready, bus.wb_valid}
        !== 5'b00010) begin
      fails++;
      $display("FAIL abort_async: we/re/busy/ready/wb=%b, want 00010",
               {bus.mem_write_enable, bus.mem_read_enable, bus.busy, bus.req_ready, bus.wb_valid});
    end
    step();
    reset = 1'b0;
    wb_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.wb_valid === 1'b1) wb_cnt++;
      step();
    end
    tests_run++;
    if (wb_cnt != 0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_quiet: wb pulses=%0d ready=%b, want 0 1", wb_cnt, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] wb_mask, rdy_mask;
    wb_t x, e;
    x.rd = 5'd6; x.data = 32'hCAFEF00D; x.err = 2'd0; x.rw = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(x);
    wb_mask  = '0;
    rdy_mask = '0;
    bus.req_is_store  = 1'b0;
    bus.req_funct3    = 3'd2;
    bus.req_addr      = 32'h200;
    bus.req_rd        = 5'd6;
    bus.mem_read_data = 32'hCAFEF00D;
    bus.mem_ack       = 1'b1;
    bus.req_valid     = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c >= 7) bus.req_valid = 1'b0;
      if (bus.req_ready === 1'b1) rdy_mask[c] = 1'b1;
      if (bus.wb_valid === 1'b1) begin
        wb_mask[c] = 1'b1;
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        tests_run++;
        if (wb_now !== e) begin
          fails++;
          $display("FAIL b2b_wb[%0d]: got %h, want %h", c, wb_now, e);
        end
      end
    end
    bus.mem_ack = 1'b0;
    tests_run++;
    if (wb_mask !== 10'h124 || rdy_mask !== 10'h248) begin
      fails++;
      $display("FAIL b2b_timing: wb=%b ready=%b, want 0100100100 1001001000", wb_mask, rdy_mask);
    end
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_is_store  = 1'b0;
    bus.req_funct3    = 3'd0;
    bus.req_addr      = 32'd0;
    bus.req_wdata     = 32'd0;
    bus.req_rd        = 5'd0;
    bus.mem_read_data = 32'd0;
    bus.mem_ack       = 1'b0;
    step();
    step();
    test_reset();
    test_lw();
    test_load_extend();
    test_store_wait();
    test_store_lanes();
    test_decode_errors();
    test_rd_zero();
    test_timeout();
    test_back_to_back();
    tests_run++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
